inst_dispatch_ctrl: RTL

- Instruction queue plus dispatch scheduler between the fetcher and the decode/dispatch stage.
- Buffers fetched instructions in a circular FIFO.
- Releases at most one instruction per cycle, only when its destination (RS or LSB) and the RoB have room.
- Flushes on RoB mispredict/clear.

---
 rtl/inst_dispatch_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/inst_dispatch_ctrl.sv
// Instruction queue and in-order dispatch scheduler.
// Fetched instructions are buffered in a circular FIFO. The head entry is
// released, at most one per cycle, when the RoB has room and its target unit
// has room: the LSB for loads/stores, the RS for everything else.
// Optional build macro DISPATCH_STAT_EN adds the stall_cycles counter and the
// rob_stall indicator.
module inst_dispatch_ctrl #(
  parameter int IQ_DEPTH_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_inst,
  input  logic [31:0] fetch_pc,
  output logic        iq_full,
  input  logic        flush,
  input  logic        RS_full,
  input  logic        LSB_full,
  input  logic        RoB_full,
  output logic        dispatch_valid,
  output logic [31:0] dispatch_inst,
  output logic [31:0] dispatch_pc,
  output logic        dispatch_to_lsb
`ifdef DISPATCH_STAT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic        rob_stall
`endif
);

  localparam int DEPTH = 1 << IQ_DEPTH_LOG;
  localparam logic [IQ_DEPTH_LOG:0] CNT_FULL = (IQ_DEPTH_LOG + 1)'(1) << IQ_DEPTH_LOG;
  localparam logic [IQ_DEPTH_LOG:0] CNT_ONE  = (IQ_DEPTH_LOG + 1)'(1);
  localparam logic [IQ_DEPTH_LOG-1:0] PTR_ONE = IQ_DEPTH_LOG'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_t;

  logic [31:0] inst_q [0:DEPTH-1];
  logic [31:0] pc_q   [0:DEPTH-1];

  logic [IQ_DEPTH_LOG-1:0] head;
  logic [IQ_DEPTH_LOG-1:0] tail;
  logic [IQ_DEPTH_LOG:0]   count;
  logic [IQ_DEPTH_LOG:0]   count_nxt;
  state_t                  state;
  state_t                  state_nxt;

  logic [31:0] head_inst;
  logic [31:0] head_pc;
  logic        head_mem;
  logic        can_go;
  logic        enq;
  logic        stall_now;

  // Full is based on the registered count only; a same-cycle dequeue does not free a slot.
  assign iq_full = (count == CNT_FULL);

  // Head classification, dispatch/enqueue decisions and next-state selection.
  always_comb begin
    head_inst = inst_q[head];
    head_pc   = pc_q[head];
    head_mem  = (head_inst[6:0] == 7'b0000011) || (head_inst[6:0] == 7'b0100011);
    can_go    = (count != '0) && !RoB_full && (head_mem ? !LSB_full : !RS_full);
    enq       = fetch_valid && !iq_full;
    stall_now = (count != '0) && !can_go;

    count_nxt = count;
    if (enq && !can_go) begin
      count_nxt = count + CNT_ONE;
    end else if (!enq && can_go) begin
      count_nxt = count - CNT_ONE;
    end

    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   state_nxt = enq ? ISSUE : EMPTY;
        default: begin
          if (count_nxt == '0) begin
            state_nxt = EMPTY;
          end else begin
            state_nxt = can_go ? ISSUE : STALL;
          end
        end
      endcase
    end
  end

  // Queue storage; payload is not reset, occupancy is tracked by count.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush && enq) begin
      inst_q[tail] <= fetch_inst;
      pc_q[tail]   <= fetch_pc;
    end
  end

  // Pointers, occupancy, FSM state and registered dispatch outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      state           <= EMPTY;
      dispatch_valid  <= 1'b0;
      dispatch_inst   <= '0;
      dispatch_pc     <= '0;
      dispatch_to_lsb <= 1'b0;
    end else if (rdy_in) begin
      state <= state_nxt;
      if (flush) begin
        head           <= '0;
        tail           <= '0;
        count          <= '0;
        dispatch_valid <= 1'b0;
      end else begin
        count          <= count_nxt;
        dispatch_valid <= can_go;
        if (enq) begin
          tail <= tail + PTR_ONE;
        end
        if (can_go) begin
          head            <= head + PTR_ONE;
          dispatch_inst   <= head_inst;
          dispatch_pc     <= head_pc;
          dispatch_to_lsb <= head_mem;
        end
      end
    end
  end

`ifdef DISPATCH_STAT_EN
  assign rob_stall = RoB_full && (count != '0);

  // Saturating count of cycles spent with a blocked, non-empty queue; survives flush.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cycles <= '0;
    end else if (rdy_in && stall_now && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
